// File: rtl/reg_mem_wb_mtx.sv
// -----------------------------------------------------------------------------
// reg_mem_wb_mtx
//
// MEM/WB pipeline register with a writeback-side matrix row assembler.
//   - Scalar results (ALU or load data) are registered for register-file
//     writeback and forwarding.
//   - Matrix word loads are gathered slot by slot into a row buffer; once all
//     MTX_WORDS slots of a row have arrived the full row is issued as a single
//     matrix register-file write.
//   - Matrix ALU results pass straight through to the matrix write port.
//
// Optional feature macro: MTX_ROW_STATUS_EN
//   When defined, adds mtx_busy (a row is partially filled) and mtx_drop_cnt
//   (saturating count of discarded partial rows).
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-low reset
//   wb_stall, wb_flush   hold everything / capture a bubble
//   me_*                 memory-stage instruction fields and data
//   wb_rd, wb_w_select   registered destination index and select
//   wb_regs_write/data   scalar register-file write port (also forwarding)
//   wb_matrix_*          matrix register-file write port
//   mtx_drop             one-cycle pulse when a partial row is discarded
// -----------------------------------------------------------------------------
module reg_mem_wb_mtx #(
   parameter int XLEN      = 32,
   parameter int MTX_WORDS = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wb_stall,
   input  logic                      wb_flush,
   input  logic [4:0]                me_rd,
   input  logic [1:0]                me_w_select,
   input  logic                      me_regs_write,
   input  logic [XLEN-1:0]           me_alu_o,
   input  logic [XLEN-1:0]           me_mem_data,
   input  logic [XLEN*MTX_WORDS-1:0] me_matrix_data,
   output logic [4:0]                wb_rd,
   output logic [1:0]                wb_w_select,
   output logic                      wb_regs_write,
   output logic [XLEN-1:0]           wb_regs_data,
   output logic                      wb_matrix_write,
   output logic [4:0]                wb_matrix_rd,
   output logic [XLEN*MTX_WORDS-1:0] wb_matrix_data,
   output logic                      mtx_drop
`ifdef MTX_ROW_STATUS_EN
   ,
   output logic                      mtx_busy,
   output logic [7:0]                mtx_drop_cnt
`endif
);

   localparam int ROW_W  = XLEN * MTX_WORDS;
   localparam int SLOT_W = 2;

   localparam logic [1:0] SEL_ALU  = 2'b00;
   localparam logic [1:0] SEL_LOAD = 2'b01;
   localparam logic [1:0] SEL_MLD  = 2'b10;
   localparam logic [1:0] SEL_MALU = 2'b11;

   // Pipeline output registers
   logic [4:0]           wb_rd_q,           wb_rd_d;
   logic [1:0]           wb_w_select_q,     wb_w_select_d;
   logic                 wb_regs_write_q,   wb_regs_write_d;
   logic [XLEN-1:0]      wb_regs_data_q,    wb_regs_data_d;
   logic                 wb_matrix_write_q, wb_matrix_write_d;
   logic [4:0]           wb_matrix_rd_q,    wb_matrix_rd_d;
   logic [ROW_W-1:0]     wb_matrix_data_q,  wb_matrix_data_d;
   logic                 mtx_drop_q,        mtx_drop_d;

   // Row assembler state
   logic [MTX_WORDS-1:0] mask_q,    mask_d;
   logic [4:0]           pend_rd_q, pend_rd_d;

   logic [SLOT_W-1:0]    slot;
   logic                 bubble;
   logic                 load_go;
   logic                 row_open;
   logic                 same_rd;
   logic                 drop_event;
   logic [MTX_WORDS-1:0] mask_upd;
   logic [ROW_W-1:0]     row_merged;

   assign slot     = me_alu_o[3:2];
   // A matrix load that does not write is nothing more than a bubble
   assign bubble   = (me_w_select == SEL_MLD) && !me_regs_write;
   assign load_go  = !wb_stall && !wb_flush && (me_w_select == SEL_MLD) && me_regs_write;
   assign row_open = (mask_q != '0);
   assign same_rd  = (me_rd == pend_rd_q);
   assign drop_event = load_go && row_open && !same_rd;

   // A new destination starts an empty row; otherwise keep accumulating
   assign mask_upd = ((row_open && same_rd) ? mask_q : '0)
                     | (MTX_WORDS'(1) << slot);

   // Row buffer words. The merged view substitutes the incoming word so a
   // completing load issues the full row in the same capture.
   genvar gi;
   generate
      for (gi = 0; gi < MTX_WORDS; gi++) begin : g_word
         logic [XLEN-1:0] word_q;
         logic            word_we;

         assign word_we = load_go && (slot == SLOT_W'(gi));

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               word_q <= '0;
            end else if (word_we) begin
               word_q <= me_mem_data;
            end
         end

         assign row_merged[gi*XLEN +: XLEN] = word_we ? me_mem_data : word_q;
      end
   endgenerate

   always_comb begin
      wb_rd_d           = wb_rd_q;
      wb_w_select_d     = wb_w_select_q;
      wb_regs_write_d   = wb_regs_write_q;
      wb_regs_data_d    = wb_regs_data_q;
      wb_matrix_write_d = wb_matrix_write_q;
      wb_matrix_rd_d    = wb_matrix_rd_q;
      wb_matrix_data_d  = wb_matrix_data_q;
      mtx_drop_d        = mtx_drop_q;
      mask_d            = mask_q;
      pend_rd_d         = pend_rd_q;

      if (!wb_stall) begin
         wb_regs_write_d   = 1'b0;
         wb_matrix_write_d = 1'b0;
         mtx_drop_d        = 1'b0;

         if (wb_flush || bubble) begin
            // Bubble: no writes; the assembler keeps any partial row
            wb_rd_d        = '0;
            wb_w_select_d  = SEL_ALU;
            wb_regs_data_d = '0;
         end else begin
            wb_rd_d        = me_rd;
            wb_w_select_d  = me_w_select;
            wb_regs_data_d = (me_w_select == SEL_LOAD) ? me_mem_data : me_alu_o;

            case (me_w_select)
               SEL_ALU, SEL_LOAD: begin
                  wb_regs_write_d = me_regs_write && (me_rd != 5'd0);
               end
               SEL_MALU: begin
                  wb_matrix_write_d = me_regs_write;
                  if (me_regs_write) begin
                     wb_matrix_rd_d   = me_rd;
                     wb_matrix_data_d = me_matrix_data;
                  end
               end
               SEL_MLD: begin
                  pend_rd_d  = me_rd;
                  mtx_drop_d = drop_event;
                  if (mask_upd == '1) begin
                     wb_matrix_write_d = 1'b1;
                     wb_matrix_rd_d    = me_rd;
                     wb_matrix_data_d  = row_merged;
                     mask_d            = '0;
                  end else begin
                     mask_d = mask_upd;
                  end
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_rd_q           <= '0;
         wb_w_select_q     <= '0;
         wb_regs_write_q   <= 1'b0;
         wb_regs_data_q    <= '0;
         wb_matrix_write_q <= 1'b0;
         wb_matrix_rd_q    <= '0;
         wb_matrix_data_q  <= '0;
         mtx_drop_q        <= 1'b0;
         mask_q            <= '0;
         pend_rd_q         <= '0;
      end else begin
         wb_rd_q           <= wb_rd_d;
         wb_w_select_q     <= wb_w_select_d;
         wb_regs_write_q   <= wb_regs_write_d;
         wb_regs_data_q    <= wb_regs_data_d;
         wb_matrix_write_q <= wb_matrix_write_d;
         wb_matrix_rd_q    <= wb_matrix_rd_d;
         wb_matrix_data_q  <= wb_matrix_data_d;
         mtx_drop_q        <= mtx_drop_d;
         mask_q            <= mask_d;
         pend_rd_q         <= pend_rd_d;
      end
   end

   assign wb_rd           = wb_rd_q;
   assign wb_w_select     = wb_w_select_q;
   assign wb_regs_write   = wb_regs_write_q;
   assign wb_regs_data    = wb_regs_data_q;
   assign wb_matrix_write = wb_matrix_write_q;
   assign wb_matrix_rd    = wb_matrix_rd_q;
   assign wb_matrix_data  = wb_matrix_data_q;
   assign mtx_drop        = mtx_drop_q;

`ifdef MTX_ROW_STATUS_EN
   logic [7:0] drop_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drop_cnt_q <= '0;
      end else if (drop_event && (drop_cnt_q != 8'hFF)) begin
         drop_cnt_q <= drop_cnt_q + 8'd1;
      end
   end

   assign mtx_busy     = row_open;
   assign mtx_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_reg_mem_wb_mtx.sv
module tb_reg_mem_wb_mtx;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         wb_stall = 1'b0;
   logic         wb_flush = 1'b1;
   logic [4:0]   me_rd = '0;
   logic [1:0]   me_w_select = '0;
   logic         me_regs_write = 1'b0;
   logic [31:0]  me_alu_o = '0;
   logic [31:0]  me_mem_data = '0;
   logic [127:0] me_matrix_data = '0;
   logic [4:0]   wb_rd;
   logic [1:0]   wb_w_select;
   logic         wb_regs_write;
   logic [31:0]  wb_regs_data;
   logic         wb_matrix_write;
   logic [4:0]   wb_matrix_rd;
   logic [127:0] wb_matrix_data;
   logic         mtx_drop;
`ifdef MTX_ROW_STATUS_EN
   logic         mtx_busy;
   logic [7:0]   mtx_drop_cnt;
`endif

   reg_mem_wb_mtx dut (
      .clk            (clk),
      .rst            (rst),
      .wb_stall       (wb_stall),
      .wb_flush       (wb_flush),
      .me_rd          (me_rd),
      .me_w_select    (me_w_select),
      .me_regs_write  (me_regs_write),
      .me_alu_o       (me_alu_o),
      .me_mem_data    (me_mem_data),
      .me_matrix_data (me_matrix_data),
      .wb_rd          (wb_rd),
      .wb_w_select    (wb_w_select),
      .wb_regs_write  (wb_regs_write),
      .wb_regs_data   (wb_regs_data),
      .wb_matrix_write(wb_matrix_write),
      .wb_matrix_rd   (wb_matrix_rd),
      .wb_matrix_data (wb_matrix_data),
      .mtx_drop       (mtx_drop)
`ifdef MTX_ROW_STATUS_EN
      ,
      .mtx_busy       (mtx_busy),
      .mtx_drop_cnt   (mtx_drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      bit           ident;   // rd/select carry a real instruction
      logic [4:0]   rd;
      logic [1:0]   sel;
      bit           rw;
      logic [31:0]  rdata;
      bit           mw;
      logic [4:0]   mrd;
      logic [127:0] mdata;
      bit           drop;
      bit           busy;
      logic [7:0]   cnt;
   } exp_t;

   exp_t sb[$];

   int checks   = 0;
   int failures = 0;
   int txn      = 0;

   // Reference model: a row is a set of collected words for one destination.
   logic [31:0] m_row [4];
   bit          m_valid [4];
   bit          m_active;
   logic [4:0]  m_pend;
   int          m_cnt;
   exp_t        m_out;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (txn %0d)", name, act, exp, txn);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 4; k++) begin
         m_row[k]   = '0;
         m_valid[k] = 1'b0;
      end
      m_active = 1'b0;
      m_pend   = '0;
      m_cnt    = 0;
      m_out    = '{default: '0};
   endtask

   task automatic clear_row();
      for (int k = 0; k < 4; k++) m_valid[k] = 1'b0;
   endtask

   // Predict the outputs resulting from the inputs currently applied.
   task automatic model_step();
      exp_t e;
      int   s;
      bit   full;
      if (wb_stall) begin
         sb.push_back(m_out);
         return;
      end
      e = '{default: '0};
      if (wb_flush || (me_w_select == 2'b10 && !me_regs_write)) begin
         e.ident = 1'b0;
      end else begin
         e.ident = 1'b1;
         e.rd    = me_rd;
         e.sel   = me_w_select;
         case (me_w_select)
            2'b00: begin e.rw = me_regs_write && (me_rd != 0); e.rdata = me_alu_o; end
            2'b01: begin e.rw = me_regs_write && (me_rd != 0); e.rdata = me_mem_data; end
            2'b11: begin e.mw = me_regs_write; e.mrd = me_rd; e.mdata = me_matrix_data; end
            default: begin
               s = int'(me_alu_o[3:2]);
               if (m_active && me_rd != m_pend) begin
                  e.drop = 1'b1;
                  if (m_cnt < 255) m_cnt++;
               end
               if (!m_active || me_rd != m_pend) clear_row();
               m_active   = 1'b1;
               m_pend     = me_rd;
               m_row[s]   = me_mem_data;
               m_valid[s] = 1'b1;
               full = m_valid[0] && m_valid[1] && m_valid[2] && m_valid[3];
               if (full) begin
                  e.mw     = 1'b1;
                  e.mrd    = m_pend;
                  e.mdata  = {m_row[3], m_row[2], m_row[1], m_row[0]};
                  m_active = 1'b0;
                  clear_row();
               end
            end
         endcase
      end
      e.busy = m_active;
      e.cnt  = 8'(m_cnt);
      m_out  = e;
      sb.push_back(e);
   endtask

   task automatic drive(input bit stall, input bit flush, input logic [4:0] rd,
                        input logic [1:0] sel, input bit rw, input logic [31:0] alu,
                        input logic [31:0] mem, input logic [127:0] mtx);
      @(negedge clk);
      wb_stall       = stall;
      wb_flush       = flush;
      me_rd          = rd;
      me_w_select    = sel;
      me_regs_write  = rw;
      me_alu_o       = alu;
      me_mem_data    = mem;
      me_matrix_data = mtx;
      if (rst) model_step();
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic ld(input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] data);
      drive(1'b0, 1'b0, rd, 2'b10, 1'b1, addr, data, rnd128());
   endtask

   task automatic release_rst();
      @(negedge clk);
      wb_stall = 1'b0;
      wb_flush = 1'b1;
      rst      = 1'b1;
      model_step();
   endtask

   task automatic do_reset();
      @(negedge clk);
      wb_stall = 1'b0;
      wb_flush = 1'b1;
      rst      = 1'b0;
      #1;
      chk("rst_wb_rd",           128'(wb_rd),           128'd0);
      chk("rst_wb_w_select",     128'(wb_w_select),     128'd0);
      chk("rst_wb_regs_write",   128'(wb_regs_write),   128'd0);
      chk("rst_wb_regs_data",    128'(wb_regs_data),    128'd0);
      chk("rst_wb_matrix_write", 128'(wb_matrix_write), 128'd0);
      chk("rst_wb_matrix_rd",    128'(wb_matrix_rd),    128'd0);
      chk("rst_wb_matrix_data",  wb_matrix_data,        128'd0);
      chk("rst_mtx_drop",        128'(mtx_drop),        128'd0);
`ifdef MTX_ROW_STATUS_EN
      chk("rst_mtx_busy",        128'(mtx_busy),        128'd0);
      chk("rst_mtx_drop_cnt",    128'(mtx_drop_cnt),    128'd0);
`endif
      model_reset();
      sb.delete();
      release_rst();
   endtask

   // Monitor: one captured instruction per rising edge while out of reset.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rst && sb.size() > 0) begin
            e = sb.pop_front();
            txn++;
            chk("regs_write",   128'(wb_regs_write),   128'(e.rw));
            chk("matrix_write", 128'(wb_matrix_write), 128'(e.mw));
            chk("mtx_drop",     128'(mtx_drop),        128'(e.drop));
            if (e.ident) begin
               chk("wb_rd",       128'(wb_rd),       128'(e.rd));
               chk("wb_w_select", 128'(wb_w_select), 128'(e.sel));
            end
            if (e.rw) chk("regs_data", 128'(wb_regs_data), 128'(e.rdata));
            if (e.mw) begin
               chk("matrix_rd",   128'(wb_matrix_rd), 128'(e.mrd));
               chk("matrix_data", wb_matrix_data,     e.mdata);
            end
`ifdef MTX_ROW_STATUS_EN
            chk("mtx_busy",     128'(mtx_busy),     128'(e.busy));
            chk("mtx_drop_cnt", 128'(mtx_drop_cnt), 128'(e.cnt));
`endif
            $display("txn %0d rd=%0d sel=%0d rw=%0d mw=%0d mrd=%0d drop=%0d",
                     txn, wb_rd, wb_w_select, wb_regs_write, wb_matrix_write,
                     wb_matrix_rd, mtx_drop);
         end
      end
   end

   initial begin
      logic [4:0] cur_rd;
      int         r;
      model_reset();
      repeat (3) @(negedge clk);
      release_rst();

      // Scalar load writeback, then the same to x0
      drive(0, 0, 5'd5, 2'b01, 1, 32'h0, 32'hDEADBEEF, '0);
      drive(0, 0, 5'd0, 2'b01, 1, 32'h0, 32'hDEADBEEF, '0);
      drive(0, 0, 5'd9, 2'b00, 1, 32'h1234_5678, 32'hFFFF_0000, '0);

      // In-order row assembly
      ld(5'd3, 32'h100, 32'h11111111);
      ld(5'd3, 32'h104, 32'h22222222);
      ld(5'd3, 32'h108, 32'h33333333);
      ld(5'd3, 32'h10C, 32'h44444444);

      // Out-of-order slots across a stall and a flushed load
      ld(5'd6, 32'h208, 32'hAAAA0002);
      ld(5'd6, 32'h200, 32'hAAAA0000);
      repeat (3) drive(1, $urandom_range(0, 1), 5'($urandom), 2'($urandom), 1, $urandom, $urandom, rnd128());
      drive(0, 1, 5'd9, 2'b10, 1, 32'h204, 32'hBAD0BAD0, rnd128());
      ld(5'd6, 32'h20C, 32'hAAAA0003);
      ld(5'd6, 32'h204, 32'hAAAA0001);

      // Destination switch discards the partial row
      ld(5'd3, 32'h0, 32'h30000000);
      ld(5'd3, 32'h4, 32'h30000001);
      ld(5'd4, 32'h0, 32'h40000000);
      ld(5'd4, 32'h4, 32'h40000001);
      ld(5'd4, 32'h8, 32'h40000002);
      ld(5'd4, 32'hC, 32'h40000003);

      // Matrix ALU pass-through while a row is pending
      ld(5'd3, 32'h0, 32'h50000000);
      ld(5'd3, 32'h4, 32'h50000001);
      drive(0, 0, 5'd7, 2'b11, 1, 32'h0, 32'h0, {4{32'hA5A5A5A5}});
      ld(5'd3, 32'h8, 32'h50000002);
      ld(5'd3, 32'hC, 32'h50000003);

      // Mid-run reset with two slots filled, then a lone slot-0 load
      ld(5'd3, 32'h0, 32'h60000000);
      ld(5'd3, 32'h4, 32'h60000001);
      do_reset();
      ld(5'd3, 32'h0, 32'h70000000);
      drive(0, 0, 5'd1, 2'b00, 0, 32'h0, 32'h0, '0);

      // Randomized traffic
      cur_rd = 5'd3;
      for (int i = 0; i < 1500; i++) begin
         r = $urandom_range(0, 99);
         if ($urandom_range(0, 99) < 12) cur_rd = 5'($urandom_range(1, 4));
         if (r < 12) begin
            drive(1, $urandom_range(0, 1), 5'($urandom), 2'($urandom), 1, $urandom, $urandom, rnd128());
         end else if (r < 20) begin
            drive(0, 1, 5'($urandom), 2'($urandom), 1, $urandom, $urandom, rnd128());
         end else if (r < 65) begin
            drive(0, 0, cur_rd, 2'b10, $urandom_range(0, 9) != 0,
                  {$urandom_range(0, 1023), 2'($urandom), 2'b00}, $urandom, rnd128());
         end else begin
            drive(0, 0, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)) ^ 2'b10 ^ 2'b10,
                  $urandom_range(0, 4) != 0, $urandom, $urandom, rnd128());
         end
      end

      drive(0, 1, '0, 2'b00, 0, '0, '0, '0);
      @(posedge clk);
      #2;
      chk("scoreboard_drained", 128'(sb.size()), 128'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end

endmodule
